alu_issue_stage: RTL and testbench

- Upstream feeder for the 8-bit add/sub ALU; owns an internal register file.
- Accepts instructions over a valid/ready handshake, reads source registers with single-level forwarding, and drives registered operands and opcode into the ALU.
- Writes the ALU result back to the register file one cycle later.
- The ALU itself (combinational, opcode 0 = A+B, 1 = A−B) is instantiated outside this block.

---
 rtl/alu_issue_stage.sv | 144 ++++++++++++++
 tb/tb_alu_issue_stage.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_stage
// Purpose  : Issue stage for an external 8-bit add/sub ALU. Holds the register
//            file, forwards the in-flight result and retires one op per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_stage #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REGS   = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_op,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic [ADDR_WIDTH-1:0] in_rs,
    input  logic [ADDR_WIDTH-1:0] in_rt,
    input  logic [DATA_WIDTH-1:0] in_imm,
    input  logic                  stall,
    output logic [DATA_WIDTH-1:0] alu_opA,
    output logic [DATA_WIDTH-1:0] alu_opB,
    output logic                  alu_ctrl,
    input  logic [DATA_WIDTH-1:0] alu_result,
    output logic                  wb_valid,
    output logic [ADDR_WIDTH-1:0] wb_reg,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic [CNT_WIDTH-1:0]  retired_count,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_data
);

    localparam logic [1:0] OP_LDI = 2'b10;
    localparam logic [1:0] OP_NOP = 2'b11;

    logic [DATA_WIDTH-1:0] regfile_q [NUM_REGS];

    logic                  ex_valid_q, ex_valid_d;
    logic [ADDR_WIDTH-1:0] ex_rd_q,    ex_rd_d;
    logic [DATA_WIDTH-1:0] opa_q,      opa_d;
    logic [DATA_WIDTH-1:0] opb_q,      opb_d;
    logic                  ctrl_q,     ctrl_d;
    logic                  wb_valid_q;
    logic [ADDR_WIDTH-1:0] wb_reg_q;
    logic [DATA_WIDTH-1:0] wb_data_q;
    logic [CNT_WIDTH-1:0]  cnt_q;

    logic                  fire;
    logic                  issue;
    logic [DATA_WIDTH-1:0] src_rs;
    logic [DATA_WIDTH-1:0] src_rt;

    // r0 is hard zero and is never forwarded, even when it is the in-flight rd.
    function automatic logic [DATA_WIDTH-1:0] src_read(
        input logic [ADDR_WIDTH-1:0] r,
        input logic                  exv,
        input logic [ADDR_WIDTH-1:0] exrd,
        input logic [DATA_WIDTH-1:0] fwd,
        input logic [DATA_WIDTH-1:0] rf
    );
        if (r == '0)
            return '0;
        else if (exv && (exrd == r) && (exrd != '0))
            return fwd;
        else
            return rf;
    endfunction

    assign in_ready = ~stall;
    assign fire     = in_valid & in_ready;
    assign issue    = fire & (in_op != OP_NOP);

    assign src_rs = src_read(in_rs, ex_valid_q, ex_rd_q, alu_result, regfile_q[in_rs]);
    assign src_rt = src_read(in_rt, ex_valid_q, ex_rd_q, alu_result, regfile_q[in_rt]);

    always_comb begin
        ex_valid_d = issue;
        ex_rd_d    = ex_rd_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        ctrl_d     = ctrl_q;
        if (issue) begin
            ex_rd_d = in_rd;
            if (in_op == OP_LDI) begin
                opa_d  = in_imm;
                opb_d  = '0;
                ctrl_d = 1'b0;
            end else begin
                opa_d  = src_rs;
                opb_d  = src_rt;
                ctrl_d = in_op[0];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid_q <= 1'b0;
            ex_rd_q    <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            ctrl_q     <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_reg_q   <= '0;
            wb_data_q  <= '0;
            cnt_q      <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_rd_q    <= ex_rd_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            ctrl_q     <= ctrl_d;
            wb_valid_q <= ex_valid_q;
            if (ex_valid_q) begin
                wb_reg_q  <= ex_rd_q;
                wb_data_q <= alu_result;
                cnt_q     <= cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++)
                regfile_q[i] <= '0;
        end else if (ex_valid_q && (ex_rd_q != '0)) begin
            regfile_q[ex_rd_q] <= alu_result;
        end
    end

    assign alu_opA       = opa_q;
    assign alu_opB       = opb_q;
    assign alu_ctrl      = ctrl_q;
    assign wb_valid      = wb_valid_q;
    assign wb_reg        = wb_reg_q;
    assign wb_data       = wb_data_q;
    assign retired_count = cnt_q;
    assign dbg_data      = regfile_q[dbg_addr];

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_stage
// Purpose  : Scoreboard bench for alu_issue_stage with a behavioural add/sub ALU.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_stage;

    localparam int CW = 4;

    logic       clock;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_op;
    logic [2:0] in_rd, in_rs, in_rt;
    logic [7:0] in_imm;
    logic       stall;
    logic [7:0] alu_opA, alu_opB;
    logic       alu_ctrl;
    logic [7:0] alu_result;
    logic       wb_valid;
    logic [2:0] wb_reg;
    logic [7:0] wb_data;
    logic [CW-1:0] retired_count;
    logic [2:0] dbg_addr;
    logic [7:0] dbg_data;

    int tests = 0;
    int fails = 0;
    logic [10:0]   sb_q [$];
    logic [CW-1:0] cnt_m = '0;

    alu_issue_stage #(
        .DATA_WIDTH(8), .NUM_REGS(8), .ADDR_WIDTH(3), .CNT_WIDTH(CW)
    ) dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt), .in_imm(in_imm),
        .stall(stall), .alu_opA(alu_opA), .alu_opB(alu_opB), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
        .retired_count(retired_count), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    assign alu_result = alu_ctrl ? (alu_opA - alu_opB) : (alu_opA + alu_opB);

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every writeback pulse must match the oldest expected retirement.
    always @(negedge clock) begin
        if (wb_valid) begin
            cnt_m = cnt_m + 1'b1;
            if (sb_q.size() == 0) begin
                chk("wb_unexpected", {21'd0, wb_reg, wb_data}, 32'hFFFF_FFFF);
            end else begin
                chk("wb_reg_data", {21'd0, wb_reg, wb_data}, {21'd0, sb_q.pop_front()});
            end
            chk("retired_count_live", {28'd0, retired_count}, {28'd0, cnt_m});
        end
    end

    task automatic issue(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs,
                         input logic [2:0] rt, input logic [7:0] imm, input logic [7:0] exp);
        in_valid = 1'b1;
        in_op    = op;
        in_rd    = rd;
        in_rs    = rs;
        in_rt    = rt;
        in_imm   = imm;
        if (!stall && op != 2'b11)
            sb_q.push_back({rd, exp});
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk_dbg(input logic [2:0] a, input logic [7:0] exp, input string nm);
        dbg_addr = a;
        #1;
        chk(nm, {24'd0, dbg_data}, {24'd0, exp});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n  = 1'b0;
        stall    = 1'b1;
        in_valid = 1'b0;
        in_op    = 2'b00;
        in_rd    = '0;
        in_rs    = '0;
        in_rt    = '0;
        in_imm   = '0;
        dbg_addr = '0;

        // In reset: in_ready tracks stall, everything else cleared.
        #1;
        chk("ready_in_reset_stall", {31'd0, in_ready}, 32'd0);
        stall = 1'b0;
        #1;
        chk("ready_in_reset", {31'd0, in_ready}, 32'd1);
        @(posedge clock);
        #1;
        chk("rst_opA", {24'd0, alu_opA}, 32'd0);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_count", {28'd0, retired_count}, 32'd0);
        reset_n = 1'b1;
        idle(1);

        // Back-to-back LDI/LDI/ADD: r2 forwarded, r1 from the regfile.
        issue(2'b10, 3'd1, 3'd0, 3'd0, 8'h05, 8'h05);
        issue(2'b10, 3'd2, 3'd0, 3'd0, 8'h03, 8'h03);
        issue(2'b00, 3'd3, 3'd1, 3'd2, 8'h00, 8'h08);
        idle(3);
        chk_dbg(3'd3, 8'h08, "dbg_r3_add");

        // Subtract wrap then dependent chain.
        issue(2'b10, 3'd1, 3'd0, 3'd0, 8'h01, 8'h01);
        issue(2'b01, 3'd4, 3'd0, 3'd1, 8'h00, 8'hFF);
        idle(3);
        chk_dbg(3'd4, 8'hFF, "dbg_r4_sub_wrap");
        issue(2'b00, 3'd4, 3'd4, 3'd1, 8'h00, 8'h00);
        issue(2'b01, 3'd6, 3'd4, 3'd1, 8'h00, 8'hFF);
        idle(3);
        chk_dbg(3'd4, 8'h00, "dbg_r4_add_wrap");
        chk_dbg(3'd6, 8'hFF, "dbg_r6_fwd_sub");

        // r0 target retires but is neither stored nor forwarded.
        issue(2'b10, 3'd0, 3'd0, 3'd0, 8'hAA, 8'hAA);
        issue(2'b00, 3'd5, 3'd0, 3'd0, 8'h00, 8'h00);
        idle(3);
        chk_dbg(3'd0, 8'h00, "dbg_r0_zero");
        chk("count_after_r0", {28'd0, retired_count}, 32'd9);

        // Stall with an op in flight: it retires, the held op waits.
        issue(2'b10, 3'd7, 3'd0, 3'd0, 8'h42, 8'h42);
        stall    = 1'b1;
        in_valid = 1'b1;
        in_op    = 2'b00;
        in_rd    = 3'd2;
        in_rs    = 3'd7;
        in_rt    = 3'd7;
        #1;
        chk("ready_stalled", {31'd0, in_ready}, 32'd0);
        repeat (4) begin
            @(posedge clock);
            #1;
        end
        chk("count_during_stall", {28'd0, retired_count}, 32'd10);
        chk("sb_drained_in_stall", sb_q.size(), 32'd0);
        stall = 1'b0;
        issue(2'b00, 3'd2, 3'd7, 3'd7, 8'h00, 8'h84);
        idle(3);
        chk_dbg(3'd2, 8'h84, "dbg_r2_after_stall");

        // Reserved op is a bubble.
        issue(2'b11, 3'd3, 3'd1, 3'd1, 8'h99, 8'h00);
        idle(3);
        chk("count_after_nop", {28'd0, retired_count}, 32'd11);
        chk_dbg(3'd3, 8'h08, "dbg_r3_after_nop");

        // Reset with an op in EXECUTE: no writeback, everything cleared.
        issue(2'b10, 3'd6, 3'd0, 3'd0, 8'h77, 8'h77);
        reset_n = 1'b0;
        sb_q.delete();
        cnt_m = '0;
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        chk("midrst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("midrst_count", {28'd0, retired_count}, 32'd0);
        for (int a = 0; a < 8; a++)
            chk_dbg(3'(a), 8'h00, "midrst_dbg");
        reset_n = 1'b1;
        idle(3);
        chk("postrst_count", {28'd0, retired_count}, 32'd0);

        // Counter wrap at 4 bits: 17 retirements leave 1.
        for (int i = 0; i < 17; i++)
            issue(2'b10, 3'((i % 7) + 1), 3'd0, 3'd0, 8'(i), 8'(i));
        idle(4);
        chk("count_wrap", {28'd0, retired_count}, 32'd1);
        chk("sb_empty_end", sb_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
